// File: rtl/kronos_types.sv
// rtl/kronos_types.sv - Kronos shared ALU opcodes and execute-stage entry type
package kronos_types;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLT  = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_AND  = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        regwr;
  } ex_entry_t;

endpackage

// File: rtl/kronos_alu.sv
// rtl/kronos_alu.sv - Kronos combinational 32-bit ALU
module kronos_alu import kronos_types::*; (
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [3:0]  aluop,
  output logic [31:0] result
);

  logic [4:0] shamt;
  assign shamt = op2[4:0];

  always_comb begin
    result = 32'd0;
    case (aluop)
      ALU_ADD:  result = op1 + op2;
      ALU_SUB:  result = op1 - op2;
      ALU_SLT:  result = {31'd0, $signed(op1) < $signed(op2)};
      ALU_SLTU: result = {31'd0, op1 < op2};
      ALU_XOR:  result = op1 ^ op2;
      ALU_OR:   result = op1 | op2;
      ALU_AND:  result = op1 & op2;
      ALU_SLL:  result = op1 << shamt;
      ALU_SRL:  result = op1 >> shamt;
      ALU_SRA:  result = $unsigned($signed(op1) >>> shamt);
      default:  result = 32'd0;
    endcase
  end

endmodule

// File: rtl/kronos_ex_stage.sv
// rtl/kronos_ex_stage.sv - Kronos execute stage with write-back register and forwarding tap
// KRONOS_EX_SKID_EN selects a two-entry skid buffer with a registered decode_rdy.
module kronos_ex_stage import kronos_types::*; (
  input  logic        clk,
  input  logic        rstz,
  input  logic        flush,
  input  logic        decode_vld,
  output logic        decode_rdy,
  input  logic [31:0] decode_op1,
  input  logic [31:0] decode_op2,
  input  logic [3:0]  decode_aluop,
  input  logic [4:0]  decode_rd,
  input  logic        decode_regwr,
  output logic        execute_vld,
  input  logic        execute_rdy,
  output logic [31:0] execute_result,
  output logic [4:0]  execute_rd,
  output logic        execute_regwr,
  output logic        fwd_vld,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data
);

  logic [31:0] alu_result;
  ex_entry_t   incoming;
  ex_entry_t   main_q;
  logic        main_vld;
  logic        in_hs;

  kronos_alu u_alu (
    .op1    (decode_op1),
    .op2    (decode_op2),
    .aluop  (decode_aluop),
    .result (alu_result)
  );

  assign incoming.result = alu_result;
  assign incoming.rd     = decode_rd;
  assign incoming.regwr  = decode_regwr;
  assign in_hs           = decode_vld & decode_rdy;

`ifdef KRONOS_EX_SKID_EN
  ex_entry_t skid_q;
  logic      skid_vld;

  assign decode_rdy = ~skid_vld;

  // skid only fills while main is stalled, so it is never occupied with main empty
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      main_vld <= 1'b0;
      main_q   <= '0;
      skid_vld <= 1'b0;
      skid_q   <= '0;
    end else if (flush) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (~main_vld | execute_rdy) begin
      if (skid_vld) begin
        main_q   <= skid_q;
        main_vld <= 1'b1;
        skid_vld <= 1'b0;
      end else if (in_hs) begin
        main_q   <= incoming;
        main_vld <= 1'b1;
      end else begin
        main_vld <= 1'b0;
      end
    end else if (in_hs) begin
      skid_q   <= incoming;
      skid_vld <= 1'b1;
    end
  end
`else
  logic out_hs;

  assign decode_rdy = ~main_vld | execute_rdy;
  assign out_hs     = main_vld & execute_rdy;

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      main_vld <= 1'b0;
      main_q   <= '0;
    end else if (flush) begin
      main_vld <= 1'b0;
    end else if (in_hs) begin
      main_q   <= incoming;
      main_vld <= 1'b1;
    end else if (out_hs) begin
      main_vld <= 1'b0;
    end
  end
`endif

  assign execute_vld    = main_vld;
  assign execute_result = main_q.result;
  assign execute_rd     = main_q.rd;
  assign execute_regwr  = main_q.regwr;

  assign fwd_vld  = main_vld & main_q.regwr & (main_q.rd != 5'd0);
  assign fwd_rd   = main_q.rd;
  assign fwd_data = main_q.result;

endmodule

// File: tb/tb_kronos_ex_stage.sv
// tb/tb_kronos_ex_stage.sv - self-checking bench for kronos_ex_stage against a FIFO model
module tb_kronos_ex_stage;
  import kronos_types::*;

  logic        clk = 1'b0;
  logic        rstz = 1'b0;
  logic        flush = 1'b0;
  logic        decode_vld = 1'b0;
  logic        decode_rdy;
  logic [31:0] decode_op1 = '0;
  logic [31:0] decode_op2 = '0;
  logic [3:0]  decode_aluop = '0;
  logic [4:0]  decode_rd = '0;
  logic        decode_regwr = 1'b0;
  logic        execute_vld;
  logic        execute_rdy = 1'b0;
  logic [31:0] execute_result;
  logic [4:0]  execute_rd;
  logic        execute_regwr;
  logic        fwd_vld;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;

  int vectors = 0;
  int miscompares = 0;

  kronos_ex_stage dut (
    .clk(clk), .rstz(rstz), .flush(flush),
    .decode_vld(decode_vld), .decode_rdy(decode_rdy),
    .decode_op1(decode_op1), .decode_op2(decode_op2), .decode_aluop(decode_aluop),
    .decode_rd(decode_rd), .decode_regwr(decode_regwr),
    .execute_vld(execute_vld), .execute_rdy(execute_rdy),
    .execute_result(execute_result), .execute_rd(execute_rd), .execute_regwr(execute_regwr),
    .fwd_vld(fwd_vld), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa;
    sa = int'(b % 32);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a + (~b) + 32'd1;
      ALU_SLT:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_XOR:  return a ^ b;
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      ALU_SLL:  return a << sa;
      ALU_SRL:  return a >> sa;
      ALU_SRA:  return (a >> sa) | ((a[31] && sa != 0) ? ~(32'hFFFFFFFF >> sa) : 32'd0);
      default:  return 32'd0;
    endcase
  endfunction

  // Model: the ordered list of accepted, not-yet-delivered entries
  ex_entry_t q[$];
  ex_entry_t nent;
  logic      exp_rdy;
  logic      m_in;
  logic      m_out;

  always @(negedge clk) begin
    if (!rstz) q.delete();
    chk("vld", 32'(execute_vld), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("result", execute_result, q[0].result);
      chk("rd", 32'(execute_rd), 32'(q[0].rd));
      chk("regwr", 32'(execute_regwr), 32'(q[0].regwr));
      chk("fwd_vld", 32'(fwd_vld), 32'(q[0].regwr && q[0].rd != 5'd0));
      chk("fwd_rd", 32'(fwd_rd), 32'(q[0].rd));
      chk("fwd_data", fwd_data, q[0].result);
    end else begin
      chk("fwd_vld_idle", 32'(fwd_vld), 32'd0);
    end
`ifdef KRONOS_EX_SKID_EN
    exp_rdy = (q.size() < 2);
`else
    exp_rdy = (q.size() == 0) || execute_rdy;
`endif
    chk("decode_rdy", 32'(decode_rdy), 32'(exp_rdy));
    if (rstz) begin
      m_in  = decode_vld && exp_rdy;
      m_out = (q.size() != 0) && execute_rdy;
      if (flush) q.delete();
      else begin
        if (m_out) void'(q.pop_front());
        if (m_in) begin
          nent.result = alu_model(decode_aluop, decode_op1, decode_op2);
          nent.rd     = decode_rd;
          nent.regwr  = decode_regwr;
          q.push_back(nent);
        end
      end
    end
  end

  task automatic set_bundle(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, input logic wr);
    decode_aluop = op; decode_op1 = a; decode_op2 = b; decode_rd = rd; decode_regwr = wr;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Offer a bundle until it is taken; returns 1 ns after the accepting edge
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic wr);
    logic r;
    int n;
    set_bundle(op, a, b, rd, wr);
    decode_vld = 1'b1;
    r = 1'b0;
    n = 0;
    while (!r && n < 50) begin
      @(negedge clk); r = decode_rdy;
      step();
      n++;
    end
    if (!r) chk("send_timeout", 32'd0, 32'd1);
    decode_vld = 1'b0;
  endtask

  initial begin
    logic r;
    int n;
    int k;
    int cyc;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_vld", 32'(execute_vld), 32'd0);
    chk("rst_result", execute_result, 32'd0);
    chk("rst_rd", 32'(execute_rd), 32'd0);
    chk("rst_regwr", 32'(execute_regwr), 32'd0);
    chk("rst_fwd_vld", 32'(fwd_vld), 32'd0);
    step();
    rstz = 1'b1;
    execute_rdy = 1'b1;
    step();
    chk("rdy_after_rst", 32'(decode_rdy), 32'd1);

    send(ALU_ADD, 32'd5, 32'd7, 5'd3, 1'b1);
    chk("add_vld", 32'(execute_vld), 32'd1);
    chk("add_result", execute_result, 32'd12);
    chk("add_rd", 32'(execute_rd), 32'd3);
    chk("add_fwd_vld", 32'(fwd_vld), 32'd1);
    chk("add_fwd_data", fwd_data, 32'd12);

    send(ALU_SUB, 32'd10, 32'd3, 5'd1, 1'b1);
    chk("sub_result", execute_result, 32'd7);
    send(ALU_SLT, 32'hFFFFFFFF, 32'd1, 5'd2, 1'b1);
    chk("slt_result", execute_result, 32'd1);
    chk("slt_vld", 32'(execute_vld), 32'd1);
    send(ALU_SLTU, 32'hFFFFFFFF, 32'd1, 5'd4, 1'b1);
    chk("sltu_result", execute_result, 32'd0);
    chk("sltu_vld", 32'(execute_vld), 32'd1);
    step();
    chk("drain_vld", 32'(execute_vld), 32'd0);

    execute_rdy = 1'b0;
    send(ALU_SRA, 32'h80000000, 32'd4, 5'd7, 1'b1);
    chk("sra_result", execute_result, 32'hF8000000);
    set_bundle(ALU_ADD, 32'd1, 32'd1, 5'd8, 1'b1);
    decode_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); r = decode_rdy;
`ifdef KRONOS_EX_SKID_EN
      chk("stall_rdy", 32'(r), 32'(i == 0));
`else
      chk("stall_rdy", 32'(r), 32'd0);
`endif
      chk("stall_result", execute_result, 32'hF8000000);
      chk("stall_vld", 32'(execute_vld), 32'd1);
      step();
      if (r) decode_vld = 1'b0;
    end
    execute_rdy = 1'b1;
    n = 0;
    while (decode_vld && n < 20) begin
      @(negedge clk); r = decode_rdy;
      step();
      if (r) decode_vld = 1'b0;
      n++;
    end
    chk("release_accept", 32'(decode_vld), 32'd0);
    n = 0;
    while (!(execute_vld && execute_rd == 5'd8) && n < 20) begin
      step();
      n++;
    end
    chk("release_order_rd", 32'(execute_rd), 32'd8);
    chk("release_result", execute_result, 32'd2);
    step();
    step();

    set_bundle(ALU_XOR, 32'h0000F0F0, 32'h0000FFFF, 5'd9, 1'b1);
    decode_vld = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    decode_vld = 1'b0;
    chk("flush_vld", 32'(execute_vld), 32'd0);
    step();
    chk("flush_never", 32'(execute_vld), 32'd0);

    execute_rdy = 1'b0;
    send(ALU_OR, 32'h00F0, 32'h000F, 5'd10, 1'b1);
    set_bundle(ALU_AND, 32'hFF00, 32'h0FF0, 5'd11, 1'b1);
    decode_vld = 1'b1;
    @(negedge clk); r = decode_rdy;
    step();
    decode_vld = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    execute_rdy = 1'b1;
    chk("flush_stall_vld", 32'(execute_vld), 32'd0);
    step();
    chk("flush_skid_gone", 32'(execute_vld), 32'd0);

    send(ALU_ADD, 32'd1, 32'd2, 5'd0, 1'b1);
    chk("rd0_vld", 32'(execute_vld), 32'd1);
    chk("rd0_fwd", 32'(fwd_vld), 32'd0);
    chk("rd0_regwr", 32'(execute_regwr), 32'd1);
    send(ALU_SLL, 32'd3, 32'd4, 5'd5, 1'b0);
    chk("nowr_vld", 32'(execute_vld), 32'd1);
    chk("nowr_fwd", 32'(fwd_vld), 32'd0);
    chk("nowr_result", execute_result, 32'd48);
    step();

    k = 0;
    cyc = 0;
    set_bundle(ALU_SUB, 32'd100, 32'd0, 5'd1, 1'b1);
    decode_vld = 1'b1;
    while (k < 8 && cyc < 100) begin
      execute_rdy = cyc[0];
      @(negedge clk); r = decode_rdy;
      step();
      cyc++;
      if (r) begin
        k++;
        if (k < 8) set_bundle(ALU_SUB, 32'd100, 32'(k * 3), 5'(k + 1), 1'b1);
        else decode_vld = 1'b0;
      end
    end
    chk("alt_all_sent", 32'(k), 32'd8);
    execute_rdy = 1'b1;
    repeat (4) step();
    chk("alt_drained", 32'(execute_vld), 32'd0);

    execute_rdy = 1'b0;
    send(ALU_SRL, 32'h80000000, 32'd31, 5'd6, 1'b1);
    #1;
    rstz = 1'b0;
    #1;
    chk("arst_vld", 32'(execute_vld), 32'd0);
    chk("arst_result", execute_result, 32'd0);
    chk("arst_rd", 32'(execute_rd), 32'd0);
    chk("arst_regwr", 32'(execute_regwr), 32'd0);
    chk("arst_fwd_vld", 32'(fwd_vld), 32'd0);
    step();
    rstz = 1'b1;
    step();
    chk("arst_rdy", 32'(decode_rdy), 32'd1);
    chk("arst_vld_after", 32'(execute_vld), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
